// File: rtl/logs_pkg.sv
// Shared definitions for the note-player voices: FSM encoding and common tempo.
package logs_pkg;

  localparam logic [1:0] LOGS_ST_IDLE = 2'd0;
  localparam logic [1:0] LOGS_ST_PLAY = 2'd1;
  localparam logic [1:0] LOGS_ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = LOGS_ST_IDLE,
    ST_PLAY = LOGS_ST_PLAY,
    ST_GAP  = LOGS_ST_GAP
  } logs_state_e;

  // Every voice and the sequencer default to this tempo so they stay in lockstep.
  localparam int unsigned LOGS_TICK_CLKS = 1024;

endpackage

// File: rtl/logs_prescaler.sv
// Duration-tick prescaler: one-cycle pulse every TICK_CLKS clocks, restartable by clear.
module logs_prescaler
  import logs_pkg::*;
#(
  parameter int unsigned TICK_CLKS = LOGS_TICK_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/logs_voice.sv
// Single-voice square-wave note player with a silent articulation gap after each note.
//   state | meaning
//   IDLE  | waiting for a note command (note_ready high)
//   PLAY  | toggling audio_out every period clocks, counting duration ticks
//   GAP   | audio silent, counting GAP_TICKS ticks before the next note
module logs_voice
  import logs_pkg::*;
#(
  parameter int unsigned PW        = 12,
  parameter int unsigned DW        = 8,
  parameter int unsigned TICK_CLKS = LOGS_TICK_CLKS,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          note_valid,
  output logic          note_ready,
  input  logic [PW-1:0] note_period,
  input  logic [DW-1:0] note_dur,
  output logic          audio_out,
  output logic          busy
);

  localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logs_state_e   state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          audio_q, audio_d;
  logic          busy_q, busy_d;
  logic          presc_clear;
  logic          tick;

  logs_prescaler #(.TICK_CLKS(TICK_CLKS)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .tick  (tick)
  );

  assign note_ready = (state_q == ST_IDLE);
  assign audio_out  = audio_q;
  assign busy       = busy_q;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    phase_d     = phase_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    audio_d     = audio_q;
    presc_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (note_valid) begin
          period_d = note_period;
          rem_d    = note_dur;
          // A zero-length note is swallowed without leaving IDLE.
          if (note_dur != '0) begin
            state_d     = ST_PLAY;
            phase_d     = '0;
            audio_d     = 1'b0;
            presc_clear = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (period_q != '0) begin
          if (phase_q == (period_q - 1'b1)) begin
            phase_d = '0;
            audio_d = ~audio_q;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        if (tick) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == DW'(1)) begin
            audio_d = 1'b0;
            phase_d = '0;
            if (GAP_TICKS > 0) begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_TICKS);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        audio_d = 1'b0;
        if (tick) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      phase_q  <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      audio_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      audio_q  <= audio_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_logs_voice.sv
// Scoreboard bench for logs_voice: per-cycle expected audio/busy/ready queued at each accept.
module tb_logs_voice;

  localparam int PW = 4;
  localparam int DW = 4;
  localparam int T  = 8;
  localparam int G  = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          note_valid;
  logic          note_ready;
  logic [PW-1:0] note_period;
  logic [DW-1:0] note_dur;
  logic          audio_out;
  logic          busy;

  typedef struct packed {
    logic audio;
    logic busy;
    logic ready;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logs_voice #(.PW(PW), .DW(DW), .TICK_CLKS(T), .GAP_TICKS(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_period (note_period),
    .note_dur    (note_dur),
    .audio_out   (audio_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference timeline: cycle c counted from the accept edge (c = 1 is the first cycle after it).
  function automatic exp_t exp_at(input int p, input int d, input int c);
    exp_t e;
    if (d == 0)                 e = '{audio: 1'b0, busy: 1'b0, ready: 1'b1};
    else if (c <= d * T)        e = '{audio: (p == 0) ? 1'b0 : 1'(((c - 1) / p) % 2), busy: 1'b1, ready: 1'b0};
    else if (c <= (d + G) * T)  e = '{audio: 1'b0, busy: 1'b1, ready: 1'b0};
    else                        e = '{audio: 1'b0, busy: 1'b0, ready: 1'b1};
    return e;
  endfunction

  task automatic pop_compare(input string name, input int c);
    exp_t e;
    if (sb_q.size() == 0) begin
      check($sformatf("%s sb_empty c%0d", name, c), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%s audio c%0d", name, c), 32'(audio_out),  32'(e.audio));
      check($sformatf("%s busy c%0d",  name, c), 32'(busy),       32'(e.busy));
      check($sformatf("%s ready c%0d", name, c), 32'(note_ready), 32'(e.ready));
    end
  endtask

  // Inputs must already be presented; the accept happens on the next rising edge.
  task automatic run_note(input string name, input int p, input int d, input bit keep_valid);
    int n;
    n = (d == 0) ? 1 : (d + G) * T + 1;
    @(posedge clk);
    for (int c = 1; c <= n; c++) sb_q.push_back(exp_at(p, d, c));
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      pop_compare(name, c);
      if (c == 1 && !keep_valid) note_valid = 1'b0;
    end
  endtask

  task automatic present(input int p, input int d);
    note_valid  = 1'b1;
    note_period = PW'(p);
    note_dur    = DW'(d);
  endtask

  initial begin
    rst_n       = 1'b0;
    note_valid  = 1'b0;
    note_period = '0;
    note_dur    = '0;

    repeat (2) begin
      @(negedge clk);
      check("rst audio", 32'(audio_out), 32'd0);
      check("rst busy",  32'(busy),      32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst ready", 32'(note_ready), 32'd1);
    check("rst busy_after", 32'(busy), 32'd0);

    present(3, 2);  run_note("basic", 3, 2, 1'b0);
    present(0, 1);  run_note("rest", 0, 1, 1'b0);
    present(5, 0);  run_note("zero_dur", 5, 0, 1'b0);
    present(2, 1);  run_note("after_zero", 2, 1, 1'b0);
    present(1, 1);  run_note("b2b_first", 1, 1, 1'b1);
    run_note("b2b_second", 1, 1, 1'b0);
    present(15, 15); run_note("max", 15, 15, 1'b0);

    // Reset dropped during cycle 5 of a note; takes effect on that cycle's closing edge.
    present(2, 3);
    @(posedge clk);
    for (int c = 1; c <= 5; c++) sb_q.push_back(exp_at(2, 3, c));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      pop_compare("mid_rst", c);
      if (c == 1) note_valid = 1'b0;
    end
    rst_n = 1'b0;
    sb_q.push_back('{audio: 1'b0, busy: 1'b0, ready: 1'b1});
    @(negedge clk);
    pop_compare("mid_rst_hit", 6);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) sb_q.push_back('{audio: 1'b0, busy: 1'b0, ready: 1'b1});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pop_compare("post_rst", c);
    end

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logs_voice.md
# logs_voice

Single-voice note player. It accepts note commands (half-period, duration) over a valid/ready handshake and produces a 1-bit square-wave audio line. Each note is followed by an articulation gap. The block sits directly upstream of the audio mixer; one instance drives each `audio_in` bit of the mixer.

## Interface

**Clocking and reset.** One clock; reset is synchronous and active-low.

**Parameters**
- `PW`, default 12: width of the half-period field, in clocks.
- `DW`, default 8: width of the duration field, in ticks.
- `TICK_CLKS`, default 1024: clocks per duration tick. Must be ≥ 1.
- `GAP_TICKS`, default 1: silent ticks after each note. 0 means no gap.

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: synchronous reset, active low.
- `note_valid`, input, 1: note command present.
- `note_ready`, output, 1: block can accept a command.
- `note_period`, input, PW: half-period in clocks. 0 means rest (silence).
- `note_dur`, input, DW: note length in ticks. 0 means discard.
- `audio_out`, output, 1: square-wave audio line, registered.
- `busy`, output, 1: high in PLAY or GAP.

## Operation

**States.** IDLE, PLAY, GAP. Encoding is held in `logs_pkg`.

**Reset.**
- State = IDLE, `audio_out` = 0, `busy` = 0.
- All counters cleared.
- `note_ready` = 1 while `rst_n` is high and the state is IDLE.

**`note_ready`** is a combinational decode of state == IDLE.

**Accept.** A command is accepted when `note_valid` and `note_ready` are both high at a rising edge. The block latches `note_period` and `note_dur`.
- `note_dur` == 0: the command is consumed and the state stays IDLE. `busy` never asserts.
- Otherwise: go to PLAY, clear the phase counter, clear the tick prescaler, clear `audio_out`, and set the remaining-ticks counter to `note_dur`.

**PLAY.**
- The phase counter increments each clock.
- When it equals `period - 1`, `audio_out` toggles and the counter clears.
- Period 1 toggles every clock.
- Period 0 holds `audio_out` = 0 for the whole note.
- The prescaler emits a one-cycle tick every `TICK_CLKS` clocks; each tick decrements the remaining count.
- On the tick that takes the count to 0:
  - go to GAP if `GAP_TICKS` > 0, else go to IDLE;
  - `audio_out` is forced to 0 on the same edge.

**GAP.**
- `audio_out` = 0.
- Counts `GAP_TICKS` ticks, then returns to IDLE.

**Widths.**
- Phase counter: PW bits. The comparison is against `period - 1` in PW bits; period 0 is never compared.
- Prescaler: max(1, $clog2(`TICK_CLKS`)) bits, wrapping at `TICK_CLKS - 1`.
- Remaining-ticks counter: DW bits. Gap counter: $clog2(`GAP_TICKS` + 1) bits.

**Boundaries.**
- Inputs are ignored outside IDLE. A `note_valid` held through PLAY/GAP is not consumed until IDLE.
- `rst_n` low in any state returns to reset values on the next edge. It overrides a simultaneous accept.
- A maximum period (2^PW − 1) and maximum duration (2^DW − 1) must not overflow.

## Timing

- The accept edge is cycle 0.
- PLAY occupies cycles 1 to D·T, where D = duration and T = `TICK_CLKS`.
- GAP occupies cycles D·T+1 to (D+G)·T, where G = `GAP_TICKS`.
- IDLE begins (`note_ready` = 1) at cycle (D+G)·T+1.
- The earliest back-to-back accept is on that cycle's edge.
- The first `audio_out` toggle is visible in cycle 1+P, where P = period. Later toggles follow every P cycles.
- `busy` and `audio_out` are registered. `note_ready` is combinational from state.
- Latency from accept to first PLAY cycle: 1 clock.

## Structure

- `logs_pkg` holds:
  - the state encoding localparams (IDLE/PLAY/GAP);
  - a shared default for `TICK_CLKS`, so all voices and the sequencer agree on tempo.
- Sub-module `logs_prescaler`:
  - parameter `TICK_CLKS`;
  - inputs `clk`, `rst_n`, `clear`; output `tick`;
  - a single-cycle pulse every `TICK_CLKS` clocks, with the count restarted by `clear`;
  - instantiated once inside `logs_voice`.
- The FSM, phase counter and duration/gap counters stay in `logs_voice`.

## Test plan

Bench parameters: PW=4, DW=4, TICK_CLKS=8, GAP_TICKS=1.

1. **Reset.** Hold `rst_n` = 0 for 2 cycles. Expect `audio_out` = 0, `busy` = 0, and `note_ready` = 1 after release.
2. **Basic note.** Accept period=3, dur=2 at cycle 0. Expect:
   - `audio_out` transitions at cycles 4, 7, 10, 13, 16;
   - `audio_out` = 0 from cycle 17 to 24;
   - `busy` high from cycle 1 to 24;
   - `note_ready` = 1 at cycle 25.
3. **Rest.** Accept period=0, dur=1. Expect `audio_out` = 0 throughout, `busy` high for cycles 1 to 16, ready at cycle 17.
4. **Zero duration.** Accept dur=0. Expect `note_ready` still 1 next cycle, `busy` never high, and the next command accepted at cycle 1.
5. **Back-to-back.** Hold `note_valid` = 1 with period=1, dur=1. Expect:
   - accepts at cycles 0 and 17;
   - `audio_out` toggles every cycle during PLAY.
6. **Reset mid-note.** Drop `rst_n` at cycle 5 of a period=2, dur=3 note. Expect `audio_out` = 0, `busy` = 0, and `note_ready` = 1 on the next edge, and no residual toggling.
